// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - control encodings, opcodes and decoded bundle type for the decode stage
package decode_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ALU1_RS1  = 2'd0;
    localparam logic [1:0] ALU1_PC   = 2'd1;
    localparam logic [1:0] ALU1_ZERO = 2'd2;
    localparam logic [1:0] ALU2_RS2  = 2'd0;
    localparam logic [1:0] ALU2_IMM  = 2'd1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       illegal;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       md_en;
        logic       csr_en;
        logic [3:0] alu_op;
        logic [2:0] imm_type;
        logic [2:0] funct3;
        logic [1:0] alu_src1;
        logic [1:0] alu_src2;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // alt selects SUB on funct3=000 and SRA on funct3=101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_logic.sv
// rtl/decode_stage_logic.sv - combinational RV32I/M/Zicsr decoder producing the control bundle and illegal flag
module decode_stage_logic
    import decode_stage_pkg::*;
#(
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       legal;
    ctrl_t      c;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        c          = '0;
        c.rd       = inst[11:7];
        c.rs1      = inst[19:15];
        c.rs2      = inst[24:20];
        c.funct3   = funct3;
        c.alu_op   = ALU_ADD;
        c.imm_type = IMM_I;
        c.alu_src1 = ALU1_RS1;
        c.alu_src2 = ALU2_RS2;
        c.wb_sel   = WB_ALU;
        legal      = 1'b1;

        case (opcode)
            OPC_OP: begin
                c.reg_write = 1'b1;
                if (funct7 == F7_BASE)
                    c.alu_op = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    c.alu_op = alu_from_funct3(funct3, 1'b1);
                else if (EN_M && funct7 == F7_MULDIV)
                    c.md_en = 1'b1;
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src2  = ALU2_IMM;
                c.alu_op    = alu_from_funct3(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
                // only shifts carry funct7 in the immediate field
                if ((funct3 == 3'b001 && funct7 != F7_BASE) ||
                    (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT))
                    legal = 1'b0;
            end
            OPC_LOAD: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src2  = ALU2_IMM;
                c.wb_sel    = WB_MEM;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    legal = 1'b0;
            end
            OPC_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src2  = ALU2_IMM;
                c.imm_type  = IMM_S;
                if (funct3 > 3'b010)
                    legal = 1'b0;
            end
            OPC_BRANCH: begin
                c.branch   = 1'b1;
                c.imm_type = IMM_B;
                case (funct3)
                    3'b000, 3'b001: c.alu_op = ALU_SUB;
                    3'b100, 3'b101: c.alu_op = ALU_SLT;
                    3'b110, 3'b111: c.alu_op = ALU_SLTU;
                    default:        legal    = 1'b0;
                endcase
            end
            OPC_JAL: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                c.alu_src1  = ALU1_PC;
                c.alu_src2  = ALU2_IMM;
                c.imm_type  = IMM_J;
                c.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                c.alu_src2  = ALU2_IMM;
                c.wb_sel    = WB_PC4;
                if (funct3 != 3'b000)
                    legal = 1'b0;
            end
            OPC_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src1  = ALU1_ZERO;
                c.alu_src2  = ALU2_IMM;
                c.imm_type  = IMM_U;
            end
            OPC_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src1  = ALU1_PC;
                c.alu_src2  = ALU2_IMM;
                c.imm_type  = IMM_U;
            end
            OPC_SYSTEM: begin
                c.reg_write = 1'b1;
                c.csr_en    = 1'b1;
                c.wb_sel    = WB_CSR;
                if (!EN_CSR || funct3 == 3'b000 || funct3 == 3'b100)
                    legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            c.illegal   = 1'b1;
            c.reg_write = 1'b0;
            c.mem_read  = 1'b0;
            c.mem_write = 1'b0;
            c.branch    = 1'b0;
            c.jump      = 1'b0;
            c.md_en     = 1'b0;
            c.csr_en    = 1'b0;
        end
        if (c.rd == 5'd0)
            c.reg_write = 1'b0;
    end

    assign ctrl = c;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with valid/ready handshake and optional skid entry
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1,
    parameter bit SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [3:0]      alu_op,
    output logic [2:0]      imm_type,
    output logic [2:0]      funct3_out,
    output logic [1:0]      alu_src1,
    output logic [1:0]      alu_src2,
    output logic [1:0]      wb_sel,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            md_en,
    output logic            csr_en,
    output logic            illegal
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t          state;
    ctrl_t           dec;
    ctrl_t           main_ctrl;
    ctrl_t           skid_ctrl;
    logic [31:0]     main_inst;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] skid_pc;
    logic            valid_r;
    logic            ready_r;
    logic            in_fire;
    logic            out_fire;

    decode_stage_logic #(
        .EN_M   (EN_M),
        .EN_CSR (EN_CSR)
    ) u_logic (
        .inst (in_inst),
        .ctrl (dec)
    );

    // without a skid entry the stage can only accept when its single slot drains this cycle
    assign in_ready  = SKID ? ready_r : (!valid_r || out_ready);
    assign out_valid = valid_r;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = valid_r && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            valid_r   <= 1'b0;
            ready_r   <= 1'b1;
            main_ctrl <= '0;
            main_inst <= '0;
            main_pc   <= '0;
            skid_ctrl <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            state   <= S_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state     <= S_ONE;
                        valid_r   <= 1'b1;
                        main_ctrl <= dec;
                        main_inst <= in_inst;
                        main_pc   <= in_pc;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= dec;
                        main_inst <= in_inst;
                        main_pc   <= in_pc;
                    end else if (in_fire && SKID) begin
                        state     <= S_TWO;
                        ready_r   <= 1'b0;
                        skid_ctrl <= dec;
                        skid_inst <= in_inst;
                        skid_pc   <= in_pc;
                    end else if (out_fire) begin
                        state   <= S_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state     <= S_ONE;
                        ready_r   <= 1'b1;
                        main_ctrl <= skid_ctrl;
                        main_inst <= skid_inst;
                        main_pc   <= skid_pc;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign out_inst   = main_inst;
    assign out_pc     = main_pc;
    assign out_rd     = main_ctrl.rd;
    assign out_rs1    = main_ctrl.rs1;
    assign out_rs2    = main_ctrl.rs2;
    assign alu_op     = main_ctrl.alu_op;
    assign imm_type   = main_ctrl.imm_type;
    assign funct3_out = main_ctrl.funct3;
    assign alu_src1   = main_ctrl.alu_src1;
    assign alu_src2   = main_ctrl.alu_src2;
    assign wb_sel     = main_ctrl.wb_sel;
    assign reg_write  = main_ctrl.reg_write;
    assign mem_read   = main_ctrl.mem_read;
    assign mem_write  = main_ctrl.mem_write;
    assign branch     = main_ctrl.branch;
    assign jump       = main_ctrl.jump;
    assign md_en      = main_ctrl.md_en;
    assign csr_en     = main_ctrl.csr_en;
    assign illegal    = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - bench for decode_stage: full-featured skid instance and a minimal single-entry instance
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            in_ready   [2];
    logic            out_valid  [2];
    logic [31:0]     out_inst   [2];
    logic [XLEN-1:0] out_pc     [2];
    logic [4:0]      out_rd     [2];
    logic [4:0]      out_rs1    [2];
    logic [4:0]      out_rs2    [2];
    logic [3:0]      alu_op     [2];
    logic [2:0]      imm_type   [2];
    logic [2:0]      funct3_out [2];
    logic [1:0]      alu_src1   [2];
    logic [1:0]      alu_src2   [2];
    logic [1:0]      wb_sel     [2];
    logic            reg_write  [2];
    logic            mem_read   [2];
    logic            mem_write  [2];
    logic            branch     [2];
    logic            jump       [2];
    logic            md_en      [2];
    logic            csr_en     [2];
    logic            illegal    [2];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cnt  [2];
    logic [63:0] fifo [2][4];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .EN_M(1'b1), .EN_CSR(1'b1), .SKID(1'b1)) u_full (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_inst(out_inst[0]), .out_pc(out_pc[0]), .out_rd(out_rd[0]), .out_rs1(out_rs1[0]),
        .out_rs2(out_rs2[0]), .alu_op(alu_op[0]), .imm_type(imm_type[0]), .funct3_out(funct3_out[0]),
        .alu_src1(alu_src1[0]), .alu_src2(alu_src2[0]), .wb_sel(wb_sel[0]), .reg_write(reg_write[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .branch(branch[0]), .jump(jump[0]),
        .md_en(md_en[0]), .csr_en(csr_en[0]), .illegal(illegal[0])
    );

    decode_stage #(.XLEN(XLEN), .EN_M(1'b0), .EN_CSR(1'b0), .SKID(1'b0)) u_min (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_inst(out_inst[1]), .out_pc(out_pc[1]), .out_rd(out_rd[1]), .out_rs1(out_rs1[1]),
        .out_rs2(out_rs2[1]), .alu_op(alu_op[1]), .imm_type(imm_type[1]), .funct3_out(funct3_out[1]),
        .alu_src1(alu_src1[1]), .alu_src2(alu_src2[1]), .wb_sel(wb_sel[1]), .reg_write(reg_write[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .branch(branch[1]), .jump(jump[1]),
        .md_en(md_en[1]), .csr_en(csr_en[1]), .illegal(illegal[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] obs_bundle(input int k);
        return {illegal[k], reg_write[k], mem_read[k], mem_write[k], branch[k], jump[k], md_en[k],
                csr_en[k], alu_op[k], imm_type[k], funct3_out[k], alu_src1[k], alu_src2[k], wb_sel[k],
                out_rd[k], out_rs1[k], out_rs2[k]};
    endfunction

    // Reference decoder, same field order as obs_bundle
    function automatic logic [38:0] model(input logic [31:0] i, input bit en_m, input bit en_csr);
        logic [3:0] f3_alu [0:7];
        logic [6:0] f7;
        logic [2:0] f3;
        bit ok, rw, mr, mw, br, jp, md, cs;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] s1, s2, wb;
        f3_alu = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        f7 = i[31:25];
        f3 = i[14:12];
        ok = 1; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; md = 0; cs = 0;
        alu = 0; imm = 0; s1 = 0; s2 = 0; wb = 0;
        case (i[6:0])
            7'h33: begin
                rw = 1;
                if (f7 == 7'h00) alu = f3_alu[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'd9;
                else if (f7 == 7'h01 && en_m) md = 1;
                else ok = 0;
            end
            7'h13: begin
                rw = 1; s2 = 1; alu = f3_alu[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) alu = 4'd9;
                    else if (f7 != 7'h00) ok = 0;
                end
            end
            7'h03: begin rw = 1; mr = 1; s2 = 1; wb = 1; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin mw = 1; s2 = 1; imm = 1; ok = (f3 <= 2); end
            7'h63: begin
                br = 1; imm = 2;
                alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd5 : 4'd6;
                ok = (f3 != 2 && f3 != 3);
            end
            7'h6f: begin rw = 1; jp = 1; s1 = 1; s2 = 1; imm = 4; wb = 2; end
            7'h67: begin rw = 1; jp = 1; s2 = 1; wb = 2; ok = (f3 == 0); end
            7'h37: begin rw = 1; s1 = 2; s2 = 1; imm = 3; end
            7'h17: begin rw = 1; s1 = 1; s2 = 1; imm = 3; end
            7'h73: begin rw = 1; cs = 1; wb = 3; ok = en_csr && f3 != 0 && f3 != 4; end
            default: ok = 0;
        endcase
        if (i[11:7] == 5'd0) rw = 0;
        if (!ok) begin rw = 0; mr = 0; mw = 0; br = 0; jp = 0; md = 0; cs = 0; end
        return {!ok, rw, mr, mw, br, jp, md, cs, alu, imm, f3, s1, s2, wb, i[11:7], i[19:15], i[24:20]};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [0:10];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 15) != 0) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    // One cycle: drive at negedge, then score both instances against the queue model
    task automatic step(input bit r, input bit v, input bit fl, input bit ordy, input logic [31:0] inst);
        logic [38:0] e, o;
        logic [63:0] head;
        bit exp_ready, ofire, ifire;
        @(negedge clk);
        rst = r; in_valid = v; flush = fl; out_ready = ordy; in_inst = inst; in_pc = $urandom;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_ready = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || ordy);
            chk($sformatf("out_valid[%0d]", k), out_valid[k], cnt[k] != 0);
            chk($sformatf("in_ready[%0d]", k), in_ready[k], exp_ready);
            ofire = (cnt[k] != 0) && ordy;
            ifire = v && exp_ready;
            if (r) begin
                cnt[k] = 0;
            end else begin
                if (ofire) begin
                    head = fifo[k][0];
                    chk($sformatf("order_inst[%0d]", k), out_inst[k], head[31:0]);
                    chk($sformatf("order_pc[%0d]", k), out_pc[k], head[63:32]);
                    e = model(head[31:0], k == 0, k == 0);
                    o = obs_bundle(k);
                    if (e[38]) chk($sformatf("illegal_flags[%0d]", k), o[38:31], e[38:31]);
                    else       chk($sformatf("bundle[%0d]", k), o, e);
                    fifo[k][0] = fifo[k][1];
                    fifo[k][1] = fifo[k][2];
                    cnt[k]--;
                end
                if (fl) cnt[k] = 0;
                else if (ifire) begin
                    fifo[k][cnt[k]] = {in_pc, in_inst};
                    cnt[k]++;
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_bundle[%0d]", tag, k), obs_bundle(k), 0);
            chk($sformatf("%s_inst_pc[%0d]", tag, k), {out_inst[k], out_pc[k]}, 0);
        end
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
        cnt[0] = 0; cnt[1] = 0;
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk_zero("reset");

        step(0, 1, 0, 1, 32'h002081B3);
        step(0, 1, 0, 1, 32'h402081B3);
        chk("add_valid", out_valid[0], 1);
        chk("add_alu", alu_op[0], 4'd0);
        chk("add_rw", reg_write[0], 1);
        chk("add_rd", out_rd[0], 5'd3);
        step(0, 1, 0, 1, 32'h00812283);
        chk("sub_alu", alu_op[0], 4'd1);
        step(0, 1, 0, 1, 32'h00000013);
        chk("lw_fields", {mem_read[0], wb_sel[0], imm_type[0], alu_src2[0], funct3_out[0]},
            {1'b1, 2'd1, 3'd0, 2'd1, 3'b010});
        step(0, 1, 0, 1, 32'h022081B3);
        chk("nop_rw_ill", {reg_write[0], illegal[0]}, 2'b00);
        step(0, 1, 0, 1, 32'hFFFFFFFF);
        chk("mul_full", {md_en[0], illegal[0]}, 2'b10);
        chk("mul_min", {illegal[1], reg_write[1], md_en[1], mem_read[1], csr_en[1]}, 5'b10000);
        step(0, 1, 0, 1, 32'h51E09073);
        chk("ffff_ill", {illegal[0], reg_write[0], mem_read[0], mem_write[0], branch[0], jump[0],
                         md_en[0], csr_en[0]}, 8'h80);
        step(0, 0, 0, 1, 0);
        chk("csr_full", {csr_en[0], wb_sel[0], reg_write[0], illegal[0]}, {1'b1, 2'd3, 1'b0, 1'b0});
        chk("csr_min", {illegal[1], csr_en[1]}, 2'b10);
        step(0, 0, 0, 1, 0);

        step(0, 1, 0, 0, 32'h00100093);
        step(0, 1, 0, 0, 32'h00200113);
        step(0, 1, 0, 0, 32'h00300193);
        chk("stall_ready", in_ready[0], 0);
        chk("stall_head", out_inst[0], 32'h00100093);
        step(0, 1, 0, 1, 32'h00300193);
        chk("drain1", out_inst[0], 32'h00100093);
        step(0, 1, 0, 1, 32'h00300193);
        chk("drain2", out_inst[0], 32'h00200113);
        step(0, 0, 0, 1, 0);
        chk("drain3", out_inst[0], 32'h00300193);
        step(0, 0, 0, 1, 0);
        chk("drained", out_valid[0], 0);

        step(0, 1, 0, 0, 32'h00400213);
        step(0, 1, 0, 0, 32'h00500293);
        step(0, 1, 1, 0, 32'h00600313);
        chk("flush_two_ready", in_ready[0], 0);
        step(0, 0, 0, 1, 0);
        chk("flush_after", {out_valid[0], in_ready[0]}, 2'b01);
        step(0, 1, 0, 0, 32'h00700393);
        step(0, 1, 1, 0, 32'h00800413);
        step(0, 0, 0, 1, 0);
        chk("flush_drop", out_valid[0], 0);
        step(0, 0, 0, 1, 0);

        step(0, 1, 0, 0, 32'h00900493);
        step(0, 1, 0, 0, 32'h00A00513);
        step(1, 1, 0, 0, 32'h00B00593);
        step(0, 0, 0, 1, 0);
        chk_zero("midrst");
        chk("midrst_hs", {out_valid[0], in_ready[0], out_valid[1], in_ready[1]}, 4'b0101);

        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 2) != 0, rand_inst());
        for (int n = 0; n < 4; n++)
            step(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
